// File: rtl/idex_stage_reg_pkg.sv
// Shared pipeline definitions: control bundle layout, bubble value and
// the per-edge action chosen for the ID/EX register.
package idex_stage_reg_pkg;

    localparam int CTRL_W = 8;

    // Bit positions inside {regwrite,memtoreg,memread,memwrite,alusrc,regdst,aluop[1:0]}
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // A bubble carries no side effects: no write-back, no memory access.
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    // What the ID/EX register does on the coming clock edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_BUBBLE = 2'd3
    } stage_action_e;

endpackage

// File: rtl/idex_stage_reg_hazard_detect.sv
// Combinational load-use detection and fetch-enable generation.
// Priority: dcache stall > branch flush > load-use hazard > normal advance.
module idex_stage_reg_hazard_detect
    import idex_stage_reg_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_rst,
    input  logic             i_idex_memread,
    input  logic             i_idex_valid,
    input  logic [REG_W-1:0] i_idex_rt,
    input  logic [REG_W-1:0] i_ifid_rs,
    input  logic [REG_W-1:0] i_ifid_rt,
    input  logic             i_ifid_valid,
    input  logic             i_mem_stall,
    input  logic             i_flush,
    output logic             o_hazard,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output stage_action_e    o_action
);

    logic w_rt_nonzero;
    logic w_rt_match;

    assign w_rt_nonzero = (i_idex_rt != '0);
    assign w_rt_match   = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);

    // A load in EX whose destination feeds the instruction in ID must wait one cycle.
    assign o_hazard = i_idex_memread && i_idex_valid && w_rt_nonzero
                      && w_rt_match && i_ifid_valid;

    // Resolve the edge action and the upstream enables; reset keeps fetch enabled.
    always_comb begin
        o_action     = ACT_LOAD;
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        if (i_rst) begin
            o_action     = ACT_HOLD;
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
        end else if (i_mem_stall) begin
            o_action     = ACT_HOLD;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else if (i_flush) begin
            o_action     = ACT_FLUSH;
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
        end else if (o_hazard) begin
            o_action     = ACT_BUBBLE;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end
    end

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, dcache-stall hold,
// branch flush and saturating stall/bubble performance counters.
module idex_stage_reg
    import idex_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_W-1:0]  ifid_rs_i,
    input  logic [REG_W-1:0]  ifid_rt_i,
    input  logic [REG_W-1:0]  ifid_rd_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              valid_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    output logic [REG_W-1:0]  idex_rs_o,
    output logic [REG_W-1:0]  idex_rt_o,
    output logic [REG_W-1:0]  idex_rd_o,
    output logic [DATA_W-1:0] idex_rs_data_o,
    output logic [DATA_W-1:0] idex_rt_data_o,
    output logic [DATA_W-1:0] idex_imm_o,
    output logic [CTRL_W-1:0] idex_ctrl_o,
    output logic              idex_valid_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_hazard;
    logic              w_pc_write;
    logic              w_ifid_write;
    stage_action_e     w_action;

    idex_stage_reg_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .i_rst          (rst_i),
        .i_idex_memread (r_ctrl[CTRL_MEMREAD]),
        .i_idex_valid   (r_valid),
        .i_idex_rt      (r_rt),
        .i_ifid_rs      (ifid_rs_i),
        .i_ifid_rt      (ifid_rt_i),
        .i_ifid_valid   (valid_i),
        .i_mem_stall    (mem_stall_i),
        .i_flush        (flush_i),
        .o_hazard       (w_hazard),
        .o_pc_write     (w_pc_write),
        .o_ifid_write   (w_ifid_write),
        .o_action       (w_action)
    );

    // Pipeline register: hold on dcache stall, squash to a bubble on flush or
    // load-use, otherwise capture the decoded instruction from ID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_ctrl    <= BUBBLE_CTRL;
            r_valid   <= 1'b0;
        end else begin
            case (w_action)
                ACT_HOLD: begin
                    r_rs      <= r_rs;
                    r_rt      <= r_rt;
                    r_rd      <= r_rd;
                    r_rs_data <= r_rs_data;
                    r_rt_data <= r_rt_data;
                    r_imm     <= r_imm;
                    r_ctrl    <= r_ctrl;
                    r_valid   <= r_valid;
                end
                ACT_FLUSH, ACT_BUBBLE: begin
                    r_rs      <= '0;
                    r_rt      <= '0;
                    r_rd      <= '0;
                    r_rs_data <= '0;
                    r_rt_data <= '0;
                    r_imm     <= '0;
                    r_ctrl    <= BUBBLE_CTRL;
                    r_valid   <= 1'b0;
                end
                default: begin
                    r_rs      <= ifid_rs_i;
                    r_rt      <= ifid_rt_i;
                    r_rd      <= ifid_rd_i;
                    r_rs_data <= rs_data_i;
                    r_rt_data <= rt_data_i;
                    r_imm     <= imm_i;
                    r_ctrl    <= ctrl_i;
                    r_valid   <= valid_i;
                end
            endcase
        end
    end

    // Stall counter: counts load-use bubbles only, sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if ((w_action == ACT_BUBBLE) && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    // Bubble counter: counts every inserted bubble, hazard or flush, sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bubble_cnt <= '0;
        end else if (((w_action == ACT_BUBBLE) || (w_action == ACT_FLUSH))
                     && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end
    end

    assign idex_rs_o      = r_rs;
    assign idex_rt_o      = r_rt;
    assign idex_rd_o      = r_rd;
    assign idex_rs_data_o = r_rs_data;
    assign idex_rt_data_o = r_rt_data;
    assign idex_imm_o     = r_imm;
    assign idex_ctrl_o    = r_ctrl;
    assign idex_valid_o   = r_valid;
    assign pc_write_o     = w_pc_write;
    assign ifid_write_o   = w_ifid_write;
    assign stall_cnt_o    = r_stall_cnt;
    assign bubble_cnt_o   = r_bubble_cnt;

    // The hazard flag is folded into w_action; keep it visible for debug.
    logic w_unused_hazard;
    assign w_unused_hazard = w_hazard;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Self-checking bench for idex_stage_reg with a behavioural EX-stage model.
module tb_idex_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int CTRL_W = 8;
    localparam int OBS_W  = 3*REG_W + 3*DATA_W + CTRL_W + 1 + 2*CNT_W;

    localparam logic [CTRL_W-1:0] C_REGWRITE = 8'h80;
    localparam logic [CTRL_W-1:0] C_LW       = 8'hE8;
    localparam logic [CTRL_W-1:0] C_ADD      = 8'h86;
    localparam int                CNT_MAX    = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [REG_W-1:0]  ifidRs, ifidRt, ifidRd;
    logic [DATA_W-1:0] rsData, rtData, imm;
    logic [CTRL_W-1:0] ctrl;
    logic              valid, memStall, flush;
    logic [REG_W-1:0]  exRs, exRt, exRd;
    logic [DATA_W-1:0] exRsData, exRtData, exImm;
    logic [CTRL_W-1:0] exCtrl;
    logic              exValid, pcWrite, ifidWrite;
    logic [CNT_W-1:0]  stallCnt, bubbleCnt;

    // Reference state: what EX should hold and how many events were counted.
    logic [REG_W-1:0]  mRs, mRt, mRd;
    logic [DATA_W-1:0] mRsData, mRtData, mImm;
    logic [CTRL_W-1:0] mCtrl;
    logic              mValid;
    int                mStalls, mBubbles;

    int compared = 0;
    int mismatched = 0;

    idex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt), .ifid_rd_i(ifidRd),
        .rs_data_i(rsData), .rt_data_i(rtData), .imm_i(imm), .ctrl_i(ctrl),
        .valid_i(valid), .mem_stall_i(memStall), .flush_i(flush),
        .idex_rs_o(exRs), .idex_rt_o(exRt), .idex_rd_o(exRd),
        .idex_rs_data_o(exRsData), .idex_rt_data_o(exRtData), .idex_imm_o(exImm),
        .idex_ctrl_o(exCtrl), .idex_valid_o(exValid),
        .pc_write_o(pcWrite), .ifid_write_o(ifidWrite),
        .stall_cnt_o(stallCnt), .bubble_cnt_o(bubbleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OBS_W-1:0] obsVec();
        return {exRs, exRt, exRd, exRsData, exRtData, exImm, exCtrl, exValid, stallCnt, bubbleCnt};
    endfunction

    function automatic logic [OBS_W-1:0] expVec();
        logic [CNT_W-1:0] s, b;
        s = CNT_W'(mStalls);
        b = CNT_W'(mBubbles);
        return {mRs, mRt, mRd, mRsData, mRtData, mImm, mCtrl, mValid, s, b};
    endfunction

    // A load in EX writing a nonzero register that the valid ID instruction reads.
    function automatic logic modelHazard();
        return mCtrl[5] && mValid && (mRt != 0) && (mRt == ifidRs || mRt == ifidRt) && valid;
    endfunction

    function automatic logic [1:0] expEnables();
        logic en;
        if (rst)           en = 1'b1;
        else if (memStall) en = 1'b0;
        else if (flush)    en = 1'b1;
        else               en = !modelHazard();
        return {en, en};
    endfunction

    task automatic modelReset();
        mRs = 0; mRt = 0; mRd = 0; mRsData = 0; mRtData = 0; mImm = 0;
        mCtrl = 0; mValid = 0; mStalls = 0; mBubbles = 0;
    endtask

    task automatic drive(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic [CTRL_W-1:0] c, input logic v,
                         input logic st, input logic fl);
        ifidRs = rs; ifidRt = rt; ifidRd = REG_W'($urandom_range(31));
        rsData = $urandom; rtData = $urandom; imm = $urandom;
        ctrl = c; valid = v; memStall = st; flush = fl;
    endtask

    // Advance one clock edge, updating the reference with the rules of the stage.
    task automatic tick();
        logic hz;
        hz = modelHazard();
        @(posedge clk);
        if (memStall) begin
        end else if (flush || hz) begin
            mRs = 0; mRt = 0; mRd = 0; mRsData = 0; mRtData = 0; mImm = 0;
            mCtrl = 0; mValid = 0;
            if (mBubbles < CNT_MAX) mBubbles++;
            if (!flush && mStalls < CNT_MAX) mStalls++;
        end else begin
            mRs = ifidRs; mRt = ifidRt; mRd = ifidRd; mRsData = rsData;
            mRtData = rtData; mImm = imm; mCtrl = ctrl; mValid = valid;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(5'd9, 5'd10, C_LW, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd10, 5'd2, C_ADD, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        compared++;
        if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL reset_regs: got %h want %h", obsVec(), expVec());
        end
        memStall = 1'b0;
        #1;
        compared++;
        if ({pcWrite, ifidWrite} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL reset_enables: got %b want 11", {pcWrite, ifidWrite});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_normal();
        drive(5'd3, 5'd4, C_REGWRITE, 1'b1, 1'b0, 1'b0);
        tick();
        compared++;
        if ({exRs, exRt, exCtrl, exValid} !== {5'd3, 5'd4, C_REGWRITE, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL normal_capture: got rs=%0d rt=%0d ctrl=%h v=%b want 3 4 80 1",
                     exRs, exRt, exCtrl, exValid);
        end
        compared++;
        if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL normal_all: got %h want %h", obsVec(), expVec());
        end
    endtask

    task automatic test_load_use();
        int stallsBefore;
        drive(5'd1, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);
        tick();
        stallsBefore = mStalls;
        drive(5'd5, 5'd2, C_ADD, 1'b1, 1'b0, 1'b0);
        #1;
        compared++;
        if ({pcWrite, ifidWrite} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL loaduse_enables: got %b want 00", {pcWrite, ifidWrite});
        end
        tick();
        compared++;
        if (obsVec() !== expVec() || exValid !== 1'b0 || int'(stallCnt) != stallsBefore + 1) begin
            mismatched++;
            $display("[TB] FAIL loaduse_bubble: got %h want %h", obsVec(), expVec());
        end
        #1;
        compared++;
        if ({pcWrite, ifidWrite} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL loaduse_release: got %b want 11", {pcWrite, ifidWrite});
        end
        tick();
        compared++;
        if (obsVec() !== expVec() || exRs !== 5'd5 || exCtrl !== C_ADD) begin
            mismatched++;
            $display("[TB] FAIL loaduse_capture: got %h want %h", obsVec(), expVec());
        end
    endtask

    task automatic test_no_hazard();
        drive(5'd1, 5'd0, C_LW, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, C_ADD, 1'b1, 1'b0, 1'b0);
        #1;
        compared++;
        if ({pcWrite, ifidWrite} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL nohaz_zero: got %b want 11", {pcWrite, ifidWrite});
        end
        drive(5'd1, 5'd7, C_LW, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(5'd5, 5'd6, C_ADD, 1'b1, 1'b0, 1'b0);
        #1;
        compared++;
        if ({pcWrite, ifidWrite} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL nohaz_unrelated: got %b want 11", {pcWrite, ifidWrite});
        end
        tick();
        compared++;
        if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL nohaz_capture: got %h want %h", obsVec(), expVec());
        end
    endtask

    task automatic test_mem_stall();
        logic [OBS_W-1:0] held;
        drive(5'd2, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);
        tick();
        held = expVec();
        for (int i = 0; i < 10; i++) begin
            drive(5'd5, 5'd3, C_ADD, 1'b1, 1'b1, 1'b0);
            #1;
            compared++;
            if ({pcWrite, ifidWrite} !== 2'b00 || obsVec() !== held) begin
                mismatched++;
                $display("[TB] FAIL stall_hold[%0d]: got %h en=%b want %h en=00",
                         i, obsVec(), {pcWrite, ifidWrite}, held);
            end
            tick();
        end
        memStall = 1'b0;
        #1;
        compared++;
        if ({pcWrite, ifidWrite} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL stall_release_hazard: got %b want 00", {pcWrite, ifidWrite});
        end
        tick();
        tick();
        compared++;
        if (obsVec() !== expVec() || exCtrl !== C_ADD) begin
            mismatched++;
            $display("[TB] FAIL stall_after: got %h want %h", obsVec(), expVec());
        end
    endtask

    task automatic test_flush_hazard();
        drive(5'd1, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd5, 5'd5, C_ADD, 1'b1, 1'b0, 1'b1);
        #1;
        compared++;
        if ({pcWrite, ifidWrite} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL flush_enables: got %b want 11", {pcWrite, ifidWrite});
        end
        tick();
        compared++;
        if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL flush_bubble: got %h want %h", obsVec(), expVec());
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        logic [CTRL_W-1:0] c;
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(1) == 1) ? C_LW : CTRL_W'($urandom) & 8'hDF;
            drive(REG_W'($urandom_range(7)), REG_W'($urandom_range(7)), c,
                  1'($urandom_range(3) != 0), 1'($urandom_range(7) == 0),
                  1'($urandom_range(7) == 0));
            #1;
            compared++;
            if ({pcWrite, ifidWrite} !== expEnables()) begin
                mismatched++;
                $display("[TB] FAIL random_enables[%0d]: got %b want %b",
                         i, {pcWrite, ifidWrite}, expEnables());
            end
            tick();
            compared++;
            if (obsVec() !== expVec()) begin
                mismatched++;
                $display("[TB] FAIL random_regs[%0d]: got %h want %h", i, obsVec(), expVec());
            end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        modelReset();
        drive(5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            drive(5'd1, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);
            tick();
            drive(5'd5, 5'd1, C_ADD, 1'b1, 1'b0, 1'b0);
            tick();
        end
        compared++;
        if (int'(stallCnt) != CNT_MAX || int'(bubbleCnt) != CNT_MAX) begin
            mismatched++;
            $display("[TB] FAIL saturate: got stall=%0d bubble=%0d want %0d",
                     stallCnt, bubbleCnt, CNT_MAX);
        end
        compared++;
        if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL saturate_all: got %h want %h", obsVec(), expVec());
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_normal();
        test_load_use();
        test_no_hazard();
        test_mem_stall();
        test_flush_hazard();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
